avalon_to_wb_bridge: RTL

Avalon-MM slave to Wishbone B3 master bridge, the reverse of the Wishbone-to-Avalon bridge used on the DDR3 ports. It lets Avalon-side masters (DMA engines, Qsys-generated IP) reach Wishbone slaves in the wb_clk domain. Avalon bursts are translated into Wishbone incrementing-burst cycles, one beat at a time.

---
 rtl/wb_bridge_pkg.sv | 19 +
 rtl/avalon_to_wb_bridge_if.sv | 46 ++++
 rtl/avalon_to_wb_bridge.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared constants, FSM encoding and CTI helper for the Avalon-MM to Wishbone B3 bridge.
package wb_bridge_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR_BEAT,
      ST_WR_NEXT,
      ST_RD_BURST
   } bridge_state_t;

   function automatic logic [2:0] cti_for(input logic burst_en, input logic last_beat);
      if (!burst_en) return CTI_CLASSIC;
      return last_beat ? CTI_EOB : CTI_INCR;
   endfunction
endpackage

// File: rtl/avalon_to_wb_bridge_if.sv
// Bus bundle for the bridge: Avalon-MM slave side plus Wishbone B3 master side.
// 'slave' is the bridge's view (an Avalon slave); 'master' is the surrounding system.
interface avalon_to_wb_bridge_if #(
   parameter int unsigned DW  = 32,
   parameter int unsigned AW  = 32,
   parameter int unsigned BCW = 3
);
   logic [AW-1:0]   s_av_address_i;
   logic [DW/8-1:0] s_av_byteenable_i;
   logic            s_av_read_i;
   logic            s_av_write_i;
   logic [DW-1:0]   s_av_writedata_i;
   logic [BCW-1:0]  s_av_burstcount_i;
   logic [DW-1:0]   s_av_readdata_o;
   logic            s_av_readdatavalid_o;
   logic            s_av_waitrequest_o;

   logic [AW-1:0]   wb_adr_o;
   logic [DW-1:0]   wb_dat_o;
   logic [DW/8-1:0] wb_sel_o;
   logic            wb_we_o;
   logic            wb_cyc_o;
   logic            wb_stb_o;
   logic [2:0]      wb_cti_o;
   logic [1:0]      wb_bte_o;
   logic [DW-1:0]   wb_dat_i;
   logic            wb_ack_i;
   logic            wb_err_i;
   logic            wb_rty_i;

   modport slave (
      input  s_av_address_i, s_av_byteenable_i, s_av_read_i, s_av_write_i,
             s_av_writedata_i, s_av_burstcount_i,
             wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
      output s_av_readdata_o, s_av_readdatavalid_o, s_av_waitrequest_o,
             wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
   );

   modport master (
      output s_av_address_i, s_av_byteenable_i, s_av_read_i, s_av_write_i,
             s_av_writedata_i, s_av_burstcount_i,
             wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
      input  s_av_readdata_o, s_av_readdatavalid_o, s_av_waitrequest_o,
             wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
   );
endinterface

// File: rtl/avalon_to_wb_bridge.sv
// Avalon-MM slave to Wishbone B3 master bridge; Avalon bursts become WB incrementing
// bursts issued one beat at a time, all WB outputs driven straight from registers.
module avalon_to_wb_bridge
   import wb_bridge_pkg::*;
#(
   parameter int unsigned DW            = 32,
   parameter int unsigned AW            = 32,
   parameter int unsigned BCW           = 3,
   parameter bit          BURST_SUPPORT = 1'b1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   avalon_to_wb_bridge_if.slave  bus,
   output logic                  bus_err_o
);
   localparam logic [AW-1:0] ADR_STEP = AW'(DW / 8);

   bridge_state_t   r_state;
   logic [AW-1:0]   r_adr;
   logic [DW-1:0]   r_dat;
   logic [DW/8-1:0] r_sel;
   logic [BCW-1:0]  r_cnt;
   logic            r_cyc;
   logic            r_stb;
   logic            r_we;
   logic [2:0]      r_cti;
   logic [DW-1:0]   r_rdata;
   logic            r_rvalid;
   logic            r_berr;

   logic            w_done;
   logic [BCW-1:0]  w_cnt_nxt;
   logic [BCW-1:0]  w_bc;

   // A retried beat is not consumed even if ack/err were also raised.
   assign w_done    = r_stb & ~bus.wb_rty_i & (bus.wb_ack_i | bus.wb_err_i);
   assign w_cnt_nxt = r_cnt - BCW'(1);
   assign w_bc      = (bus.s_av_burstcount_i == '0) ? BCW'(1) : bus.s_av_burstcount_i;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= ST_IDLE;
         r_adr    <= '0;
         r_dat    <= '0;
         r_sel    <= '0;
         r_cnt    <= '0;
         r_cyc    <= 1'b0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_cti    <= CTI_CLASSIC;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_berr   <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         r_berr   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.s_av_write_i || bus.s_av_read_i) begin
                  r_adr   <= bus.s_av_address_i;
                  r_sel   <= bus.s_av_byteenable_i;
                  r_cnt   <= w_bc;
                  r_cyc   <= 1'b1;
                  r_stb   <= 1'b1;
                  r_cti   <= cti_for(BURST_SUPPORT, w_bc == BCW'(1));
                  r_we    <= bus.s_av_write_i;
                  r_dat   <= bus.s_av_writedata_i;
                  r_state <= bus.s_av_write_i ? ST_WR_BEAT : ST_RD_BURST;
               end
            end
            ST_WR_BEAT: begin
               if (w_done) begin
                  r_berr <= bus.wb_err_i;
                  r_cnt  <= w_cnt_nxt;
                  r_adr  <= r_adr + ADR_STEP;
                  r_stb  <= 1'b0;
                  if (w_cnt_nxt == '0) begin
                     r_cyc   <= 1'b0;
                     r_we    <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_WR_NEXT;
                  end
               end
            end
            ST_WR_NEXT: begin
               if (bus.s_av_write_i) begin
                  r_dat   <= bus.s_av_writedata_i;
                  r_sel   <= bus.s_av_byteenable_i;
                  r_stb   <= 1'b1;
                  r_cti   <= cti_for(BURST_SUPPORT, r_cnt == BCW'(1));
                  r_state <= ST_WR_BEAT;
               end
            end
            ST_RD_BURST: begin
               if (w_done) begin
                  r_rdata  <= bus.wb_dat_i;
                  r_rvalid <= 1'b1;
                  r_berr   <= bus.wb_err_i;
                  r_cnt    <= w_cnt_nxt;
                  r_adr    <= r_adr + ADR_STEP;
                  r_cti    <= cti_for(BURST_SUPPORT, w_cnt_nxt == BCW'(1));
                  if (w_cnt_nxt == '0) begin
                     r_cyc   <= 1'b0;
                     r_stb   <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.s_av_waitrequest_o   = wb_rst_i | ~((r_state == ST_IDLE) | (r_state == ST_WR_NEXT));
   assign bus.s_av_readdata_o      = r_rdata;
   assign bus.s_av_readdatavalid_o = r_rvalid;
   assign bus.wb_adr_o             = r_adr;
   assign bus.wb_dat_o             = r_dat;
   assign bus.wb_sel_o             = r_sel;
   assign bus.wb_we_o              = r_we;
   assign bus.wb_cyc_o             = r_cyc;
   assign bus.wb_stb_o             = r_stb;
   assign bus.wb_cti_o             = r_cti;
   assign bus.wb_bte_o             = BTE_LINEAR;
   assign bus_err_o                = r_berr;
endmodule
